l_sub_feed: RTL and testbench
=============================

# l_sub_feed

Upstream feeder for the L-function divider. Accepts a 4096-bit Paillier value `u` and the 2048-bit modulus `n` as LSB-first 128-bit blocks with arbitrary gaps, computes `u - 1` on the fly with block-serial borrow, and buffers both operands. It then replays them to the divider as one gap-free burst: a one-cycle `valid_in` arm pulse followed by `NCNT` consecutive `data_vld_in` beats. The divider then produces `(u-1)/n`.

## Interface
- `N`, 4096, width of `u` in bits.
- `M`, 2048, width of `n` in bits.
- `BLOCK`, 128, beat width in bits.
- Derived values: `NCNT = N/BLOCK` (32) and `MCNT = M/BLOCK` (16). Both are localparams.

- `clk`  in  1  single clock; all logic acts on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle request to begin a job; honoured only in IDLE.
- `u_blk`  in  BLOCK  block of `u`, LSB block first.
- `n_blk`  in  BLOCK  block of `n`; sampled only on beats 0..MCNT-1.
- `in_vld`  in  1  input beat valid.
- `in_ready`  out  1  high only in LOAD; a beat transfers when `in_vld & in_ready`.
- `div_valid_in`  out  1  arm pulse to the divider.
- `div_data_vld`  out  1  burst valid to the divider.
- `div_x`  out  BLOCK  block of `u-1`.
- `div_y`  out  BLOCK  block of `n`, or zero on beats ≥ MCNT.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  underflow flag (`u == 0`); valid while `done` is high.

## Operation
- **Outputs:** all outputs are registered. Reset value of every output is 0.
- **Storage:** an `x_buf` of NCNT×BLOCK and a `y_buf` of MCNT×BLOCK, addressed by a 6-bit beat counter `idx`.
- **IDLE:**
  - On `start`: clear `idx`, set `borrow = 1`, go to LOAD.
  - `in_vld` is ignored while in IDLE.
- **LOAD:**
  - On each transfer, compute `x_buf[idx] = u_blk - borrow` (modulo 2^BLOCK).
  - Update `borrow <= borrow & (u_blk == 0)`.
  - If `idx < MCNT`, store `y_buf[idx] = n_blk`.
  - Increment `idx`.
  - On the transfer with `idx == NCNT-1`, go to CHECK.
  - Gaps in `in_vld` stall LOAD indefinitely with no timeout.
- **CHECK (1 cycle):**
  - If `borrow == 1` and underflow checking is enabled, go to DONE with `err = 1`.
  - Otherwise clear `idx` and go to ARM.
- **ARM (1 cycle):** `div_valid_in = 1`, `div_data_vld = 0`.
- **STREAM (NCNT cycles):**
  - `div_data_vld = 1`, `div_x = x_buf[idx]`.
  - `div_y = idx < MCNT ? y_buf[idx] : 0`.
  - `idx` increments every cycle. There is no backpressure; the divider must be idle when armed.
  - After beat NCNT-1, go to DONE.
- **DONE (1 cycle):**
  - `done = 1` and `div_data_vld = 0`. This low cycle is what makes the divider leave its input state.
  - Then go to IDLE.
- **Boundaries:**
  - `start` while busy is ignored.
  - A `u` whose low blocks are all zero propagates the borrow correctly. Example: `u = 2^128` gives block0 = all-ones and block1 = 0.
  - `rst` asserted in any state returns to IDLE on the next edge. Outputs clear, buffer contents are don't-care, and no partial burst resumes.

## Timing
- Let the final LOAD transfer occur on edge `c`.
- CHECK occupies `c+1`, ARM `c+2`, STREAM `c+3 … c+34`, DONE `c+35`, and IDLE from `c+36`.
- Start-to-first-`in_ready` latency is 1 cycle: `start` is sampled at edge `s` and `in_ready = 1` from `s+1`.
- Underflow abort: DONE falls at `c+2`, and neither `div_valid_in` nor `div_data_vld` ever asserts.
- Minimum job period with gap-free input: 1 + 32 + 1 + 1 + 32 + 1 = 68 cycles.

## Configuration
- `L_SUB_UNDERFLOW_CHK_EN`
  - **Defined:** the CHECK state aborts on `u == 0` as described, and `err` pulses with `done`.
  - **Undefined:** `err` is tied to 0 and CHECK always proceeds to ARM. The wrapped value (all ones, `2^N - 1`) is streamed, and timing is identical to a normal job.

## Test plan
- **Basic:** `u = n + 1`, with `n = 0x…0D` (MCNT random blocks, top bit set) and contiguous input.
  - Burst `div_x` equals `n` block for block.
  - `div_y[16..31] = 0`.
  - `div_valid_in` pulses exactly one cycle before the first `div_data_vld`.
  - `done` asserts 33 cycles after ARM.
- **Borrow chain:** `u = 2^1024`.
  - `div_x` blocks 0..7 = `0xFFFF…FFFF`, block 8 onward = 0.
  - `err = 0`.
- **Gappy input:** `in_vld` random at 30% duty.
  - Same stored result as the contiguous case.
  - The STREAM burst is still 32 consecutive beats.
- **Underflow:** `u = 0`.
  - With `L_SUB_UNDERFLOW_CHK_EN`: `done` and `err` pulse at `c+2`, and no `div_*` activity.
  - Without it: 32 beats of all ones are streamed and `err = 0`.
- **Reset mid-STREAM:** assert `rst` on beat 10.
  - All outputs are 0 on the next edge and the block is back in IDLE.
  - A fresh job afterwards completes correctly.
- **Ignored start:** `start` pulsed during LOAD and again during STREAM.
  - No state or `idx` disturbance, and exactly one `done`.

Source files
------------

// File: rtl/l_sub_feed_if.sv
// Beat bus between the operand source, l_sub_feed and the L-function divider.
// master = source/divider side, slave = l_sub_feed.
interface l_sub_feed_if #(
   parameter int BLOCK = 128
);
   logic [BLOCK-1:0] u_blk;
   logic [BLOCK-1:0] n_blk;
   logic             in_vld;
   logic             in_ready;
   logic             div_valid_in;
   logic             div_data_vld;
   logic [BLOCK-1:0] div_x;
   logic [BLOCK-1:0] div_y;

   modport master (
      output u_blk, n_blk, in_vld,
      input  in_ready, div_valid_in, div_data_vld, div_x, div_y
   );

   modport slave (
      input  u_blk, n_blk, in_vld,
      output in_ready, div_valid_in, div_data_vld, div_x, div_y
   );
endinterface

// File: rtl/l_sub_feed.sv
// Buffers u-1 (block-serial borrow) and n, then replays both to the divider as one gap-free burst.
// Define L_SUB_UNDERFLOW_CHK_EN to abort jobs with u == 0 and raise err alongside done.
//   state    | meaning
//   S_IDLE   | waiting for start
//   S_LOAD   | accepting input beats, computing u-1 into x_buf
//   S_CHECK  | underflow decision
//   S_ARM    | divider arm pulse
//   S_STREAM | NCNT consecutive burst beats
//   S_DONE   | completion pulse, burst valid low
module l_sub_feed #(
   parameter int N     = 4096,
   parameter int M     = 2048,
   parameter int BLOCK = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   l_sub_feed_if.slave bus,
   output logic        busy,
   output logic        done,
   output logic        err
);
   localparam int         NCNT   = N / BLOCK;
   localparam int         MCNT   = M / BLOCK;
   localparam int         AW     = $clog2(NCNT);
   localparam int         MAW    = $clog2(MCNT);
   localparam logic [5:0] NCNT_W = 6'(NCNT);
   localparam logic [5:0] LAST_W = 6'(NCNT - 1);
   localparam logic [5:0] MCNT_W = 6'(MCNT);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CHECK, S_ARM, S_STREAM, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [5:0]       idx_q, idx_d;
   logic             borrow_q, borrow_d;
   logic             in_rdy_q, in_rdy_d;
   logic             arm_q, arm_d;
   logic             dv_q, dv_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [BLOCK-1:0] x_q, x_d;
   logic [BLOCK-1:0] y_q, y_d;
   logic             xfer;
   logic             abort;
   logic             load_beat;

   logic [BLOCK-1:0] x_buf [NCNT];
   logic [BLOCK-1:0] y_buf [MCNT];

   assign xfer = bus.in_vld & in_rdy_q;

`ifdef L_SUB_UNDERFLOW_CHK_EN
   assign abort = borrow_q;
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         in_rdy_q <= 1'b0;
         arm_q    <= 1'b0;
         dv_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         in_rdy_q <= in_rdy_d;
         arm_q    <= arm_d;
         dv_q     <= dv_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         x_q      <= x_d;
         y_q      <= y_d;
      end
   end

   // Buffer contents need no reset; every job rewrites all beats before replay.
   always_ff @(posedge clk) begin
      if (xfer) begin
         x_buf[idx_q[AW-1:0]] <= bus.u_blk - BLOCK'(borrow_q);
         if (idx_q < MCNT_W) y_buf[idx_q[MAW-1:0]] <= bus.n_blk;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      borrow_d  = borrow_q;
      arm_d     = 1'b0;
      dv_d      = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      x_d       = '0;
      y_d       = '0;
      load_beat = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d    = '0;
               borrow_d = 1'b1;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               borrow_d = borrow_q & (bus.u_blk == '0);
               idx_d    = idx_q + 6'd1;
               if (idx_q == LAST_W) state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (abort) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               idx_d   = '0;
               state_d = S_ARM;
               arm_d   = 1'b1;
            end
         end
         S_ARM: begin
            state_d   = S_STREAM;
            load_beat = 1'b1;
         end
         // Outputs are registered, so idx runs one ahead of the beat on the bus.
         S_STREAM: begin
            if (idx_q == NCNT_W) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               load_beat = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (load_beat) begin
         dv_d  = 1'b1;
         x_d   = x_buf[idx_q[AW-1:0]];
         if (idx_q < MCNT_W) y_d = y_buf[idx_q[MAW-1:0]];
         idx_d = idx_q + 6'd1;
      end

      in_rdy_d = (state_d == S_LOAD);
      busy_d   = (state_d != S_IDLE);
   end

   assign bus.in_ready     = in_rdy_q;
   assign bus.div_valid_in = arm_q;
   assign bus.div_data_vld = dv_q;
   assign bus.div_x        = x_q;
   assign bus.div_y        = y_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign err              = err_q;
endmodule

// File: tb/tb_l_sub_feed.sv
// Self-checking bench for l_sub_feed: arithmetic model of u-1 plus a cycle-window timing model.
module tb_l_sub_feed;
   localparam int     N     = 4096;
   localparam int     M     = 2048;
   localparam int     BLOCK = 128;
   localparam int     NCNT  = 32;
   localparam int     MCNT  = 16;
   localparam longint NEVER = 64'd1 << 40;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy, done, err;

   l_sub_feed_if #(.BLOCK(BLOCK)) bus();

   l_sub_feed #(.N(N), .M(M), .BLOCK(BLOCK)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks  = 0;
   int n_errors  = 0;
   int done_seen = 0;

   // model of the current job
   logic [N-1:0] exp_x;
   logic [M-1:0] exp_n;
   bit           exp_abort = 1'b0;
   bit           job_on    = 1'b0;
   longint       job_s     = NEVER;
   longint       job_c     = NEVER;
   longint       job_kill  = NEVER;

   task automatic chk(input string name, input logic [BLOCK-1:0] act, input logic [BLOCK-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [BLOCK-1:0] blk_of(input logic [N-1:0] v, input int k);
      return v[k*BLOCK +: BLOCK];
   endfunction

   function automatic logic [N-1:0] minus_one(input logic [N-1:0] u);
      return u - N'(1);
   endfunction

   // Expected outputs after edge e follow from the start edge s and the final-transfer edge c.
   always @(negedge clk) begin
      longint e, fin, k;
      bit     act, e_busy, e_rdy, e_arm, e_dv, e_done;
      e      = cyc;
      act    = job_on && (e >= job_s) && (e < job_kill);
      fin    = exp_abort ? job_c + 1 : job_c + 34;
      e_busy = act && (e <= fin);
      e_rdy  = act && (e < job_c);
      e_arm  = act && !exp_abort && (e == job_c + 1);
      e_dv   = act && !exp_abort && (e >= job_c + 2) && (e <= job_c + 33);
      e_done = act && (e == fin);
      chk("ctrl{busy,rdy,arm,dv,done}",
          BLOCK'({busy, bus.in_ready, bus.div_valid_in, bus.div_data_vld, done}),
          BLOCK'({e_busy, e_rdy, e_arm, e_dv, e_done}));
      if (e_dv) begin
         k = e - job_c - 2;
         chk("div_x", bus.div_x, exp_x[int'(k)*BLOCK +: BLOCK]);
         if (k < MCNT) chk("div_y", bus.div_y, exp_n[int'(k)*BLOCK +: BLOCK]);
         else          chk("div_y_zero", bus.div_y, '0);
      end
      if (e_done) chk("err", BLOCK'(err), BLOCK'(exp_abort));
      if (done) done_seen++;
   end

   function automatic logic [BLOCK-1:0] rnd_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic run_job(input logic [N-1:0] u, input logic [M-1:0] n, input int duty,
                          input bit poke, input bit kill);
      int     k, guard, d0;
      bit     vld;
      longint fin;
      exp_x = minus_one(u);
`ifdef L_SUB_UNDERFLOW_CHK_EN
      exp_abort = (u == '0);
`else
      exp_abort = 1'b0;
`endif
      exp_n    = n;
      d0       = done_seen;
      job_c    = NEVER;
      job_kill = NEVER;
      job_s    = cyc + 1;
      job_on   = 1'b1;
      start      = 1'b1;
      bus.in_vld = 1'b1;
      bus.u_blk  = rnd_blk();
      bus.n_blk  = rnd_blk();
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      guard = 0;
      while (k < NCNT && guard < 4000) begin
         vld        = ($urandom_range(99) < duty);
         bus.in_vld = vld;
         bus.u_blk  = u[k*BLOCK +: BLOCK];
         if (k < MCNT) bus.n_blk = n[k*BLOCK +: BLOCK];
         else          bus.n_blk = rnd_blk();
         start = poke && (k == 5);
         @(posedge clk); #1;
         if (vld) k++;
         guard++;
      end
      bus.in_vld = 1'b0;
      start      = 1'b0;
      if (k < NCNT) chk("load_timeout_beats", BLOCK'(k), BLOCK'(NCNT));
      job_c = cyc;
      fin   = exp_abort ? job_c + 1 : job_c + 34;
      if (kill) begin
         while (cyc < job_c + 12) begin @(posedge clk); #1; end
         rst      = 1'b1;
         job_kill = cyc + 1;
         @(posedge clk); #1;
         rst = 1'b0;
         chk("rst_ctrl", BLOCK'({busy, bus.in_ready, bus.div_valid_in, bus.div_data_vld, done, err}), '0);
         chk("rst_x", bus.div_x, '0);
         chk("rst_y", bus.div_y, '0);
         repeat (3) begin @(posedge clk); #1; end
         chk("done_count_killed", BLOCK'(done_seen - d0), '0);
      end else begin
         while (cyc <= fin) begin
            start = poke && (cyc == job_c + 10);
            @(posedge clk); #1;
         end
         start = 1'b0;
         chk("done_count", BLOCK'(done_seen - d0), BLOCK'(1));
      end
      job_on = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0]     u, p;
      logic [M-1:0]     n;
      logic [BLOCK-1:0] ones;
      ones       = '1;
      rst        = 1'b1;
      start      = 1'b0;
      bus.in_vld = 1'b0;
      bus.u_blk  = '0;
      bus.n_blk  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_x", bus.div_x, '0);
      chk("reset_y", bus.div_y, '0);
      chk("reset_err", BLOCK'(err), '0);
      rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // pin the model against hand-computed values
      p = '0; p[128] = 1'b1;
      chk("pin_2p128_b0", blk_of(minus_one(p), 0), ones);
      chk("pin_2p128_b1", blk_of(minus_one(p), 1), '0);
      p = '0; p[1024] = 1'b1;
      chk("pin_2p1024_b7", blk_of(minus_one(p), 7), ones);
      chk("pin_2p1024_b8", blk_of(minus_one(p), 8), '0);
      p = N'(5);
      chk("pin_5_b0", blk_of(minus_one(p), 0), BLOCK'(4));
      p = '0;
      chk("pin_0_b31", blk_of(minus_one(p), 31), ones);

      // basic: u = n + 1, contiguous
      for (int i = 0; i < MCNT; i++) n[i*BLOCK +: BLOCK] = rnd_blk();
      n[M-1] = 1'b1;
      n[7:0] = 8'h0D;
      u = N'(n) + N'(1);
      run_job(u, n, 100, 1'b0, 1'b0);
      chk("basic_model_x_eq_n", exp_x[BLOCK-1:0], n[BLOCK-1:0]);

      // borrow chain: u = 2^1024
      u = '0; u[1024] = 1'b1;
      run_job(u, n, 100, 1'b0, 1'b0);

      // gappy input, start poked during LOAD and STREAM
      u = N'(n) + N'(1);
      run_job(u, n, 30, 1'b1, 1'b0);

      // u = 2^128
      u = '0; u[128] = 1'b1;
      run_job(u, n, 70, 1'b0, 1'b0);

      // underflow
      run_job('0, n, 100, 1'b0, 1'b0);

      // reset during STREAM beat 10, then a fresh job
      for (int i = 0; i < NCNT; i++) u[i*BLOCK +: BLOCK] = rnd_blk();
      run_job(u, n, 100, 1'b0, 1'b1);
      run_job(u, n, 100, 1'b0, 1'b0);

      // random jobs, some with zero low blocks to exercise the borrow chain
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < NCNT; i++) u[i*BLOCK +: BLOCK] = rnd_blk();
         for (int i = 0; i < MCNT; i++) n[i*BLOCK +: BLOCK] = rnd_blk();
         for (int i = 0; i < int'($urandom_range(0, 4)); i++) u[i*BLOCK +: BLOCK] = '0;
         run_job(u, n, int'($urandom_range(20, 100)), j[0], 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
